// File: rtl/executor_commit_scan.sv
// executor_commit_scan
//   Commits a falling piece into matrix memory and reports which of the rows
//   it covers became full.
//
//   Flow: accept (eIDLE) -> one merged window write (eWrite, valid/ready)
//         -> dim_p+1 cycle row read-back scan (eScan) -> one-cycle result
//         pulse (eDone).
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   v_i / ready_o             commit request handshake (ready only in eIDLE)
//   pos_x_i, pos_y_i          window top-left column / row
//   shape_i, shape_on_board_i piece bits and board bits under the window,
//                             row-major, bit [r*dim_p+c]
//   mm_write_*                merged-window write to matrix memory
//   mm_rd_v_o, mm_rd_y_o      row read request; mm_rd_data_i returns the row
//                             one cycle later
//   done_o                    one-cycle pulse, line_mask_o/line_cnt_o valid
//   line_mask_o, line_cnt_o   full-row mask for rows pos_y..pos_y+dim_p-1
//                             and its popcount; held until the next commit
module executor_commit_scan #(
  parameter int width_p  = 16,
  parameter int height_p = 32,
  parameter int dim_p    = 4,
  localparam int xw_p    = $clog2(width_p),
  localparam int yw_p    = $clog2(height_p),
  localparam int cw_p    = $clog2(dim_p+1),
  // row-sum width: wide enough that pos_y+k never wraps
  localparam int sw_p    = ((yw_p > cw_p) ? yw_p : cw_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [xw_p-1:0]         pos_x_i,
  input  logic [yw_p-1:0]         pos_y_i,
  input  logic [dim_p*dim_p-1:0]  shape_i,
  input  logic [dim_p*dim_p-1:0]  shape_on_board_i,
  output logic                    mm_write_v_o,
  input  logic                    mm_write_ready_i,
  output logic [xw_p-1:0]         mm_write_x_o,
  output logic [yw_p-1:0]         mm_write_y_o,
  output logic [dim_p*dim_p-1:0]  mm_write_data_o,
  output logic                    mm_rd_v_o,
  output logic [yw_p-1:0]         mm_rd_y_o,
  input  logic [width_p-1:0]      mm_rd_data_i,
  output logic                    done_o,
  output logic [dim_p-1:0]        line_mask_o,
  output logic [cw_p-1:0]         line_cnt_o
);

  typedef enum logic [1:0] {eIDLE, eWrite, eScan, eDone} state_e;

  state_e                  state;
  logic [xw_p-1:0]         pos_x_r;
  logic [yw_p-1:0]         pos_y_r;
  logic [dim_p*dim_p-1:0]  data_r;
  logic [cw_p-1:0]         k_r;       // scan counter 0..dim_p
  logic                    rd_prev;   // read issued in the previous scan cycle
  logic [dim_p-1:0]        acc;       // full-row accumulator
  logic [dim_p-1:0]        acc_next;
  logic [sw_p-1:0]         rd_sum;
  logic                    scan_last;
  logic                    row_full;

  function automatic logic [cw_p-1:0] popcnt(input logic [dim_p-1:0] m);
    logic [cw_p-1:0] s;
    s = '0;
    for (int i = 0; i < dim_p; i++) s = s + cw_p'(m[i]);
    return s;
  endfunction

  // Row address and bounds test are evaluated one bit wider than yw_p so a
  // window hanging off the bottom never aliases back onto row 0.
  assign rd_sum    = sw_p'(pos_y_r) + sw_p'(k_r);
  assign scan_last = (k_r == cw_p'(dim_p));
  assign row_full  = rd_prev & (&mm_rd_data_i);

  // Data in this cycle belongs to the read issued at k-1.
  always_comb begin
    acc_next = acc;
    for (int r = 0; r < dim_p; r++)
      if (row_full && (k_r == cw_p'(r + 1))) acc_next[r] = 1'b1;
  end

  assign ready_o         = (state == eIDLE);
  assign mm_write_v_o    = (state == eWrite);
  assign done_o          = (state == eDone);
  assign mm_rd_v_o       = (state == eScan) && !scan_last &&
                           (rd_sum < sw_p'(height_p));
  assign mm_rd_y_o       = rd_sum[yw_p-1:0];
  assign mm_write_x_o    = pos_x_r;
  assign mm_write_y_o    = pos_y_r;
  assign mm_write_data_o = data_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= eIDLE;
      pos_x_r     <= '0;
      pos_y_r     <= '0;
      data_r      <= '0;
      k_r         <= '0;
      rd_prev     <= 1'b0;
      acc         <= '0;
      line_mask_o <= '0;
      line_cnt_o  <= '0;
    end else begin
      case (state)
        eIDLE: begin
          if (v_i) begin
            pos_x_r <= pos_x_i;
            pos_y_r <= pos_y_i;
            data_r  <= shape_i | shape_on_board_i;
            state   <= eWrite;
          end
        end
        eWrite: begin
          if (mm_write_ready_i) begin
            k_r     <= '0;
            acc     <= '0;
            rd_prev <= 1'b0;
            state   <= eScan;
          end
        end
        eScan: begin
          k_r     <= k_r + 1'b1;
          rd_prev <= mm_rd_v_o;
          acc     <= acc_next;
          if (scan_last) begin
            // Result lands together with the done_o cycle.
            line_mask_o <= acc_next;
            line_cnt_o  <= popcnt(acc_next);
            state       <= eDone;
          end
        end
        eDone:   state <= eIDLE;
        default: state <= eIDLE;
      endcase
    end
  end

endmodule
